// File: rtl/xor_stream_pkg.sv
// Shared types and helpers for the XOR stream checksum block.
// Optional expected-checksum compare is enabled by defining XOR_STREAM_CHECK_EN.
package xor_stream_pkg;

  // IDLE: no beat of the current frame accepted yet.
  // ACTIVE: at least one beat accepted, closing beat still outstanding.
  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } xs_state_t;

  // Width needed to hold a frame length of 0..max_len without wrapping.
  function automatic int calc_len_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/xor_stream_checksum_if.sv
// Stream-in / result-out bundle for xor_stream_checksum.
// Optional in_expect/out_match exist only when XOR_STREAM_CHECK_EN is defined.
//
// Handshake: a transfer happens on a rising clk edge where valid && ready.
// The producer holds data stable while valid is high and ready is low; the
// consumer may toggle ready freely. in_ready is derived combinationally from
// the output slot (free, or draining this cycle).
interface xor_stream_checksum_if #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 9
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_xsum;
  logic [LEN_W-1:0] out_len;
  logic             out_parity;
  logic             out_ovf;
`ifdef XOR_STREAM_CHECK_EN
  logic [WIDTH-1:0] in_expect;
  logic             out_match;
`endif

  // Checksum block side.
  modport slave (
`ifdef XOR_STREAM_CHECK_EN
    input  in_expect,
    output out_match,
`endif
    input  in_valid,
    input  in_data,
    input  in_last,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_xsum,
    output out_len,
    output out_parity,
    output out_ovf
  );

  // Word source / result consumer side.
  modport master (
`ifdef XOR_STREAM_CHECK_EN
    output in_expect,
    input  out_match,
`endif
    output in_valid,
    output in_data,
    output in_last,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_xsum,
    input  out_len,
    input  out_parity,
    input  out_ovf
  );

endinterface

// File: rtl/xor_reduce.sv
// Combinational reduction XOR: 1 when an odd number of input bits are set.
module xor_reduce #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] data,
  output logic             parity
);

  assign parity = ^data;

endmodule

// File: rtl/xor_stream_checksum.sv
// Framed XOR checksum generator: accumulates WIDTH-bit words until in_last or
// MAX_LEN beats, then presents checksum, length, parity and overflow flag.
// Define XOR_STREAM_CHECK_EN to add in_expect / out_match comparison.
module xor_stream_checksum
  import xor_stream_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int MAX_LEN = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  xor_stream_checksum_if.slave  bus,
  output xs_state_t             dbg_state
);

  localparam int LEN_W = calc_len_w(MAX_LEN);

  xs_state_t        state_q;
  xs_state_t        state_d;
  logic [WIDTH-1:0] acc_q;
  logic [LEN_W-1:0] count_q;

  logic             out_valid_q;
  logic [WIDTH-1:0] xsum_q;
  logic [LEN_W-1:0] len_q;
  logic             parity_q;
  logic             ovf_q;

  logic             accept;
  logic             at_max;
  logic             closing;
  logic [LEN_W-1:0] count_inc;
  logic [WIDTH-1:0] acc_next;
  logic             parity_next;

  // The slot frees in the same cycle it drains, so a full pipeline never stalls.
  assign bus.in_ready = !out_valid_q || bus.out_ready;

  assign accept    = bus.in_valid && bus.in_ready;
  // count stays below MAX_LEN between beats, so count+1 fits in LEN_W bits.
  assign count_inc = count_q + LEN_W'(1);
  assign at_max    = (count_inc == LEN_W'(MAX_LEN));
  assign closing   = accept && (bus.in_last || at_max);
  assign acc_next  = acc_q ^ bus.in_data;

  xor_reduce #(.WIDTH(WIDTH)) u_parity (
    .data   (acc_next),
    .parity (parity_next)
  );

  // Next-state: any non-closing beat lands in ACTIVE, a closing beat returns to IDLE.
  always_comb begin
    state_d = state_q;
    if (accept) begin
      state_d = closing ? IDLE : ACTIVE;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Running accumulator and beat count; cleared on close so partial frames never leak.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q   <= '0;
      count_q <= '0;
    end else if (closing) begin
      acc_q   <= '0;
      count_q <= '0;
    end else if (accept) begin
      acc_q   <= acc_next;
      count_q <= count_inc;
    end
  end

  // Result slot: loads on close (even while draining), clears valid on a bare drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      xsum_q      <= '0;
      len_q       <= '0;
      parity_q    <= 1'b0;
      ovf_q       <= 1'b0;
    end else if (closing) begin
      out_valid_q <= 1'b1;
      xsum_q      <= acc_next;
      len_q       <= count_inc;
      parity_q    <= parity_next;
      ovf_q       <= at_max && !bus.in_last;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

`ifdef XOR_STREAM_CHECK_EN
  logic match_q;

  // Compare against the expectation presented with the closing beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      match_q <= 1'b0;
    end else if (closing) begin
      match_q <= (acc_next == bus.in_expect);
    end
  end

  assign bus.out_match = match_q;
`endif

  assign bus.out_valid  = out_valid_q;
  assign bus.out_xsum   = xsum_q;
  assign bus.out_len    = len_q;
  assign bus.out_parity = parity_q;
  assign bus.out_ovf    = ovf_q;
  assign dbg_state      = state_q;

endmodule
